// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, error codes, defaults.
package fetch_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_ERR   = 3'd5
    } fetch_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_code_e;

endpackage

// File: rtl/fetch_timer.sv
// Saturating response-wait counter; expired flags the last allowed cycle.
module fetch_timer
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles, holding at TIMEOUT so the value never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != CNT_W'(TIMEOUT))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The cycle seeing count TIMEOUT-1 is the TIMEOUT-th waited cycle.
    assign expired = (r_cnt >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC -> imem req/gnt/rvalid -> decode valid/ready, with flush and errors.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              fetch_en,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              pc_adv,
    output logic              fetch_err,
    output logic [1:0]        err_code
);

    fetch_state_e      r_state, w_state_nxt;
    logic              r_req, w_req_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_instr, w_instr_nxt;
    logic [ADDR_W-1:0] r_ipc, w_ipc_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_err, w_err_nxt;
    logic [1:0]        r_code, w_code_nxt;
    logic              w_tmr_clr, w_tmr_en, w_tmr_expired;

    fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_tmr_clr),
        .en      (w_tmr_en),
        .expired (w_tmr_expired)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_instr <= '0;
            r_ipc   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_instr <= w_instr_nxt;
            r_ipc   <= w_ipc_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // Next state and next output values; flush outranks every other input.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_instr_nxt = r_instr;
        w_ipc_nxt   = r_ipc;
        w_valid_nxt = r_valid;
        w_err_nxt   = r_err;
        w_code_nxt  = r_code;
        w_tmr_clr   = 1'b0;
        w_tmr_en    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (fetch_en && !flush) begin
                    if (pc_in[1:0] == 2'b00) begin
                        w_addr_nxt  = pc_in;
                        w_req_nxt   = 1'b1;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = ERR_MISALIGN;
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    // A granted read will still answer, so a flush here must drain it.
                    w_req_nxt   = 1'b0;
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = flush ? ST_DRAIN : ST_WAIT;
                end else if (flush) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_tmr_en = 1'b1;
                if (flush) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else if (imem_rvalid) begin
                    w_instr_nxt = imem_rdata;
                    w_ipc_nxt   = r_addr;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (w_tmr_expired) begin
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = ERR_TIMEOUT;
                    w_state_nxt = ST_ERR;
                end
            end
            ST_HOLD: begin
                if (flush || instr_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                w_tmr_en = 1'b1;
                if (imem_rvalid || w_tmr_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (flush) begin
                    w_err_nxt   = 1'b0;
                    w_code_nxt  = ERR_NONE;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // PC advance is combinational so the PC mux loads in the consuming cycle.
    assign pc_adv = (r_state == ST_HOLD) && instr_ready && !flush;

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_out   = r_instr;
    assign instr_pc    = r_ipc;
    assign instr_valid = r_valid;
    assign fetch_err   = r_err;
    assign err_code    = r_code;

endmodule
